// File: rtl/l2_pmem_burst_adapter_if.sv
// Bus bundle between the L2 controller, the burst adapter and main memory.
// slave = adapter view, master = controller/memory view.
interface l2_pmem_burst_adapter_if #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
);
    logic                pmem_read;
    logic                pmem_write;
    logic [ADDR_W-1:0]   pmem_address;
    logic [LINE_W-1:0]   pmem_wdata;
    logic [LINE_W-1:0]   pmem_rdata;
    logic                pmem_resp;
    logic [ADDR_W-1:0]   burst_address;
    logic                burst_read;
    logic                burst_write;
    logic [BURST_W-1:0]  burst_wdata;
    logic [BURST_W-1:0]  burst_rdata;
    logic                burst_resp;

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata, burst_rdata, burst_resp,
        output pmem_rdata, pmem_resp, burst_address, burst_read, burst_write, burst_wdata
    );

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata, burst_rdata, burst_resp,
        input  pmem_rdata, pmem_resp, burst_address, burst_read, burst_write, burst_wdata
    );
endinterface

// File: rtl/l2_pmem_burst_adapter.sv
// Serializes whole-line L2 pmem requests into ascending narrow bursts and reassembles reads.
// Optional L2_ADAPTER_ERR_EN adds a sticky proto_err output for request-protocol violations.
module l2_pmem_burst_adapter #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    l2_pmem_burst_adapter_if.slave  bus
`ifdef L2_ADAPTER_ERR_EN
    ,
    output logic                    proto_err
`endif
);
    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LINE_W-1:0]   wline_q, wline_d;
    logic [LINE_W-1:0]   rdata_q, rdata_d;
    logic [ADDR_W-1:0]   baddr_q, baddr_d;
    logic [BURST_W-1:0]  bwdata_q, bwdata_d;
    logic                resp_q, resp_d;
    logic                bread_q, bread_d;
    logic                bwrite_q, bwrite_d;
    logic [CNT_W-1:0]    cnt_next_s;
    logic                last_s;

    // Next-state, counter and datapath update for the burst FSM
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wline_d    = wline_q;
        rdata_d    = rdata_q;
        baddr_d    = baddr_q;
        bwdata_d   = bwdata_q;
        resp_d     = 1'b0;
        bread_d    = bread_q;
        bwrite_d   = bwrite_q;
        last_s     = (cnt_q == LAST_CNT);
        cnt_next_s = last_s ? {CNT_W{1'b0}} : (cnt_q + CNT_W'(1));

        case (state_q)
            IDLE: begin
                // Write wins so a dirty victim is flushed before any refill
                if (bus.pmem_write) begin
                    state_d  = WRITE;
                    wline_d  = bus.pmem_wdata;
                    baddr_d  = bus.pmem_address & ALIGN_MASK;
                    cnt_d    = {CNT_W{1'b0}};
                    bwdata_d = bus.pmem_wdata[BURST_W-1:0];
                    bwrite_d = 1'b1;
                end else if (bus.pmem_read) begin
                    state_d  = READ;
                    baddr_d  = bus.pmem_address & ALIGN_MASK;
                    cnt_d    = {CNT_W{1'b0}};
                    bread_d  = 1'b1;
                end else begin
                    state_d  = IDLE;
                end
            end
            READ: begin
                if (bus.burst_resp) begin
                    rdata_d[BURST_W*cnt_q +: BURST_W] = bus.burst_rdata;
                    cnt_d = cnt_next_s;
                    if (last_s) begin
                        state_d = DONE;
                        bread_d = 1'b0;
                        resp_d  = 1'b1;
                    end else begin
                        state_d = READ;
                    end
                end else begin
                    state_d = READ;
                end
            end
            WRITE: begin
                if (bus.burst_resp) begin
                    cnt_d    = cnt_next_s;
                    bwdata_d = wline_q[BURST_W*cnt_next_s +: BURST_W];
                    if (last_s) begin
                        state_d  = DONE;
                        bwrite_d = 1'b0;
                        resp_d   = 1'b1;
                    end else begin
                        state_d  = WRITE;
                    end
                end else begin
                    state_d = WRITE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                bread_d  = 1'b0;
                bwrite_d = 1'b0;
            end
        endcase
    end

    // FSM state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            wline_q  <= {LINE_W{1'b0}};
            rdata_q  <= {LINE_W{1'b0}};
            baddr_q  <= {ADDR_W{1'b0}};
            bwdata_q <= {BURST_W{1'b0}};
            resp_q   <= 1'b0;
            bread_q  <= 1'b0;
            bwrite_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wline_q  <= wline_d;
            rdata_q  <= rdata_d;
            baddr_q  <= baddr_d;
            bwdata_q <= bwdata_d;
            resp_q   <= resp_d;
            bread_q  <= bread_d;
            bwrite_q <= bwrite_d;
        end
    end

    assign bus.pmem_rdata    = rdata_q;
    assign bus.pmem_resp     = resp_q;
    assign bus.burst_address = baddr_q;
    assign bus.burst_read    = bread_q;
    assign bus.burst_write   = bwrite_q;
    assign bus.burst_wdata   = bwdata_q;

`ifdef L2_ADAPTER_ERR_EN
    logic err_q, err_d;

    // Sticky violation flag: conflicting requests, dropped request mid-burst, beat while idle
    always_comb begin
        err_d = err_q
              | ((state_q == IDLE) & bus.pmem_read & bus.pmem_write)
              | (((state_q == READ) | (state_q == WRITE)) & ~bus.pmem_read & ~bus.pmem_write)
              | ((state_q == IDLE) & bus.burst_resp);
    end

    // Error flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign proto_err = err_q;
`endif
endmodule

// File: tb/tb_l2_pmem_burst_adapter.sv
// Self-checking bench for l2_pmem_burst_adapter: directed vector table, reset/stray-beat
// sequences and randomized transactions against a line-level reference model.
module tb_l2_pmem_burst_adapter;
    localparam int LW = 256;
    localparam int BW = 64;
    localparam int AW = 32;
    localparam int NB = LW / BW;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    l2_pmem_burst_adapter_if #(.LINE_W(LW), .BURST_W(BW), .ADDR_W(AW)) bus_if ();
`ifdef L2_ADAPTER_ERR_EN
    logic proto_err;
`endif

    l2_pmem_burst_adapter #(.LINE_W(LW), .BURST_W(BW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
`ifdef L2_ADAPTER_ERR_EN
        ,
        .proto_err (proto_err)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;
    logic [LW-1:0] model_rdata = '0;   // last fully completed read line

    typedef struct {
        bit            rd;
        bit            wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wline;
        logic [LW-1:0] rline;
        logic [31:0]   mask;      // bit c set: memory returns a beat in cycle c
        int            exp_resp;
        logic [AW-1:0] exp_baddr;
        logic [LW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int i = 0; i < LW / 32; i++) v[32*i +: 32] = $urandom();
        return v;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pmem_resp"},   bus_if.pmem_resp,     1'b0);
        chk({tag, "_burst_read"},  bus_if.burst_read,    1'b0);
        chk({tag, "_burst_write"}, bus_if.burst_write,   1'b0);
        chk({tag, "_pmem_rdata"},  bus_if.pmem_rdata,    '0);
        chk({tag, "_burst_addr"},  bus_if.burst_address, '0);
        chk({tag, "_burst_wdata"}, bus_if.burst_wdata,   '0);
    endtask

    // Called at the falling edge of cycle 0 with the DUT idle; returns at the falling edge of the
    // idle cycle after pmem_resp, ready for a back-to-back request.
    task automatic do_txn(input bit rd, input bit wr, input logic [AW-1:0] addr,
                          input logic [LW-1:0] wline, input logic [LW-1:0] rline,
                          input logic [31:0] mask, input int gap_pct,
                          input int exp_resp, input logic [AW-1:0] exp_baddr);
        bit is_wr;
        bit done;
        bit r;
        int beat;
        is_wr = wr;
        done  = 1'b0;
        beat  = 0;
        bus_if.pmem_read    = rd;
        bus_if.pmem_write   = wr;
        bus_if.pmem_address = addr;
        bus_if.pmem_wdata   = wline;
        for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
            @(negedge clk);
            if (beat < NB) begin
                chk("burst_read",  bus_if.burst_read,    !is_wr);
                chk("burst_write", bus_if.burst_write,   is_wr);
                chk("burst_addr",  bus_if.burst_address, exp_baddr);
                chk("early_resp",  bus_if.pmem_resp,     1'b0);
                if (is_wr) begin
                    chk("burst_wdata", bus_if.burst_wdata, wline[BW*beat +: BW]);
                    chk("rdata_hold",  bus_if.pmem_rdata,  model_rdata);
                end
                // Request inputs are scrambled; only the latched copies may matter now
                bus_if.pmem_address = $urandom();
                bus_if.pmem_wdata   = rand_line();
                if (mask != 32'd0) r = (cyc < 32) ? mask[cyc] : 1'b0;
                else               r = ($urandom_range(99) >= gap_pct);
                bus_if.burst_resp  = r;
                bus_if.burst_rdata = r ? rline[BW*beat +: BW] : {$urandom(), $urandom()};
                if (r) beat++;
            end else begin
                if (!is_wr) model_rdata = rline;
                chk("pmem_resp",      bus_if.pmem_resp,   1'b1);
                chk("done_bread",     bus_if.burst_read,  1'b0);
                chk("done_bwrite",    bus_if.burst_write, 1'b0);
                chk("done_rdata",     bus_if.pmem_rdata,  model_rdata);
                if (exp_resp > 0) chk("resp_cycle", cyc, exp_resp);
                bus_if.burst_resp = 1'b0;
                bus_if.pmem_read  = 1'b0;
                bus_if.pmem_write = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL txn_timeout: got no pmem_resp within 300 cycles, required one");
            bus_if.burst_resp = 1'b0;
            bus_if.pmem_read  = 1'b0;
            bus_if.pmem_write = 1'b0;
        end
        @(negedge clk);
        chk("resp_one_cycle", bus_if.pmem_resp,   1'b0);
        chk("idle_bread",     bus_if.burst_read,  1'b0);
        chk("idle_bwrite",    bus_if.burst_write, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [LW-1:0] line_a;
        logic [LW-1:0] line_b;
        logic [AW-1:0] a;
        int            kind;

        bus_if.pmem_read    = 1'b0;
        bus_if.pmem_write   = 1'b0;
        bus_if.pmem_address = '0;
        bus_if.pmem_wdata   = '0;
        bus_if.burst_rdata  = '0;
        bus_if.burst_resp   = 1'b0;

        line_a = {64'h4444444444444444, 64'h3333333333333333,
                  64'h2222222222222222, 64'h1111111111111111};
        line_b = {64'hCAFEF00DCAFEF00D, 64'h0000000000000001,
                  64'h8000000000000000, 64'h5A5A5A5A5A5A5A5A};
        vecs[0] = '{1'b1, 1'b0, 32'h0000_1234, '0, line_a,
                    32'h0000_001E, 5, 32'h0000_1220, line_a};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_8F7C,
                    {64'hA3A3A3A3A3A3A3A3, 64'hA2A2A2A2A2A2A2A2,
                     64'hA1A1A1A1A1A1A1A1, 64'hA0A0A0A0A0A0A0A0}, '0,
                    32'h0000_024C, 10, 32'h0000_8F60, line_a};
        vecs[2] = '{1'b1, 1'b1, 32'hDEAD_BEEF,
                    {64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                     64'h0F0F0F0F0F0F0F0F, 64'hF0F0F0F0F0F0F0F0}, rand_line(),
                    32'h0000_001E, 5, 32'hDEAD_BEE0, line_a};
        vecs[3] = '{1'b1, 1'b0, 32'hFFFF_FFFF, '0, line_b,
                    32'h0000_00AA, 8, 32'hFFFF_FFE0, line_b};

        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("por_hold");
`ifdef L2_ADAPTER_ERR_EN
        chk("err_reset", proto_err, 1'b0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table; consecutive entries run back-to-back
        for (int i = 0; i < 4; i++) begin
            do_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wline, vecs[i].rline,
                   vecs[i].mask, 0, vecs[i].exp_resp, vecs[i].exp_baddr);
            chk("vec_rdata", bus_if.pmem_rdata, vecs[i].exp_rdata);
`ifdef L2_ADAPTER_ERR_EN
            chk("vec_proto_err", proto_err, (i >= 2));
`endif
        end

        // Reset in the middle of a read after two beats
        bus_if.pmem_read    = 1'b1;
        bus_if.pmem_address = 32'h0000_4040;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            bus_if.burst_resp  = 1'b1;
            bus_if.burst_rdata = {$urandom(), $urandom()};
        end
        @(negedge clk);
        bus_if.burst_resp = 1'b0;
        rst_n = 1'b0;
        bus_if.pmem_read = 1'b0;
        #1 chk_reset_outputs("midrst");
`ifdef L2_ADAPTER_ERR_EN
        chk("midrst_err", proto_err, 1'b0);
`endif
        model_rdata = '0;
        @(negedge clk);
        chk_reset_outputs("midrst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_no_resp", bus_if.pmem_resp, 1'b0);
        line_a = rand_line();
        do_txn(1'b1, 1'b0, 32'h0000_4040, '0, line_a, 32'h0000_001E, 0, 5, 32'h0000_4040);
        chk("post_rst_rdata", bus_if.pmem_rdata, line_a);

        // Stray beats while idle must not move the FSM or the counter
        for (int c = 0; c < 3; c++) begin
            bus_if.burst_resp  = 1'b1;
            bus_if.burst_rdata = {$urandom(), $urandom()};
            @(negedge clk);
            chk("stray_resp",   bus_if.pmem_resp,   1'b0);
            chk("stray_bread",  bus_if.burst_read,  1'b0);
            chk("stray_bwrite", bus_if.burst_write, 1'b0);
            chk("stray_rdata",  bus_if.pmem_rdata,  model_rdata);
        end
        bus_if.burst_resp = 1'b0;
`ifdef L2_ADAPTER_ERR_EN
        chk("stray_err", proto_err, 1'b1);
`endif
        line_b = rand_line();
        do_txn(1'b1, 1'b0, 32'h0000_0ABC, '0, line_b, 32'h0000_001E, 0, 5, 32'h0000_0AA0);
        chk("after_stray_rdata", bus_if.pmem_rdata, line_b);

        // Randomized traffic with random beat gaps
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(2);
            a    = $urandom();
            do_txn(kind != 1, kind != 0, a, rand_line(), rand_line(), 32'd0,
                   $urandom_range(60), 0, a & 32'hFFFF_FFE0);
        end
        chk("final_rdata", bus_if.pmem_rdata, model_rdata);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/l2_pmem_burst_adapter.md
# l2_pmem_burst_adapter

Responder for the L2 cache's physical-memory port. It accepts whole-line `pmem_read`/`pmem_write` requests from the L2 controller and serializes each one into a fixed-length burst of narrow beats toward main memory. For reads, it reassembles the returned beats into a full line. It returns a single-cycle `pmem_resp` when the transaction completes.

## Interface
Parameters:
- `LINE_W`, 256, cache line width in bits.
- `BURST_W`, 64, memory beat width in bits; `BEATS = LINE_W/BURST_W` (4); `LINE_W` must be an integer multiple of `BURST_W`.
- `ADDR_W`, 32, byte address width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `pmem_read` in 1: line read request, held until `pmem_resp`.
- `pmem_write` in 1: line write request, held until `pmem_resp`.
- `pmem_address` in `ADDR_W`: line address.
- `pmem_wdata` in `LINE_W`: write line.
- `pmem_rdata` out `LINE_W`: assembled read line.
- `pmem_resp` out 1: one-cycle completion pulse.
- `burst_address` out `ADDR_W`: line-aligned burst address.
- `burst_read` out 1: burst read request.
- `burst_write` out 1: burst write request.
- `burst_wdata` out `BURST_W`: current write beat.
- `burst_rdata` in `BURST_W`: read beat, valid when `burst_resp`=1.
- `burst_resp` in 1: one beat transferred this cycle.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - `pmem_write`=1 → latch address and `pmem_wdata`, clear beat counter, go to WRITE.
  - Else `pmem_read`=1 → latch address, clear counter, go to READ.
  - Write has priority if both are asserted.
- READ:
  - `burst_read`=1.
  - Each cycle with `burst_resp`=1 stores `burst_rdata` into line slice `[BURST_W*cnt +: BURST_W]` and increments `cnt`.
  - After the beat with `cnt`=`BEATS`-1 → DONE.
- WRITE:
  - `burst_write`=1; `burst_wdata` = latched slice `cnt`.
  - Each `burst_resp` advances `cnt`.
  - After the last beat → DONE.
- DONE: `pmem_resp`=1 for exactly one cycle → IDLE.
- Beat order is ascending: beat 0 = bits `[BURST_W-1:0]`.
- `cnt` is `$clog2(BEATS)` bits wide and wraps to 0 after the last beat.
- `burst_address` = latched address with the low `$clog2(LINE_W/8)` bits forced to 0.
- Beats need not be consecutive. Gaps with `burst_resp`=0 hold state and counter.
- `burst_resp` in IDLE or DONE is ignored.
- Requests are not re-sampled until the adapter returns to IDLE. Changes to `pmem_*` inputs mid-transaction are ignored because the latched copies are used.
- `pmem_rdata` holds its value until the next read overwrites it. Write transactions leave it unchanged.

## Timing
- Reset values:
  - state = IDLE, `cnt` = 0.
  - `pmem_resp`, `burst_read`, `burst_write` = 0.
  - `pmem_rdata`, `burst_address`, `burst_wdata` = 0.
- All outputs are registered or decoded from registered state. There is no combinational path from `pmem_*` or `burst_*` inputs to outputs.
- Request sampled in IDLE at cycle 0 → `burst_read`/`burst_write` high from cycle 1.
- With beats at cycles k..k+BEATS-1:
  - `pmem_resp` is high in cycle k+BEATS.
  - `pmem_rdata` is valid in that cycle.
- Minimum latency, with beats in cycles 1–4: `pmem_resp` in cycle 5.
- `burst_read`/`burst_write` deassert in the cycle after the last beat (DONE).
- The cycle after `pmem_resp` is IDLE, so a back-to-back request is accepted there. This is the normal write-back followed by refill sequence.
- Asserting `rst_n`=0 mid-burst immediately returns all state to reset values. A partial line is discarded and no `pmem_resp` is issued.

## Configuration
- `L2_ADAPTER_ERR_EN` defined:
  - Adds output `proto_err` (1 bit, reset 0, sticky until reset).
  - It sets on any of:
    - `pmem_read` and `pmem_write` both high in IDLE.
    - `pmem_read`/`pmem_write` both low during READ or WRITE.
    - `burst_resp`=1 in IDLE.
- Undefined: no `proto_err` port and no detection logic. Datapath behaviour is identical in both cases.

## Test plan
- Read: `pmem_address`=0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 in cycles 1–4:
  - `burst_address`=0x0000_1220.
  - `pmem_resp` only in cycle 5.
  - `pmem_rdata`={0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write: `pmem_wdata` slices 0xA0..A3; `burst_resp` with gaps in cycles 2, 3, 6, 9:
  - `burst_wdata` steps A0→A1→A2→A3 only on resp cycles.
  - `pmem_resp` in cycle 10.
- Write then read back-to-back (write-back, then refill):
  - Second request accepted the cycle after the first `pmem_resp`.
  - `pmem_rdata` unchanged by the write.
- Simultaneous `pmem_read`=`pmem_write`=1: write burst issued first; with `L2_ADAPTER_ERR_EN`, `proto_err`=1 next cycle.
- `rst_n` low after 2 read beats:
  - All outputs 0 within the reset cycle.
  - A fresh read then completes normally with `cnt` starting at beat 0.
- Stray `burst_resp` in IDLE: no state change and no `pmem_resp`.
